// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, converts fetch pulses into a memory read
// handshake with timeout and a one-deep request queue, and strobes fetched words out.
module instr_fetch #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_ram_in,
    input  logic              en_pc_pulse,
    input  logic [1:0]        pc_ctrl,
    input  logic [7:0]        offset_addr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DWIDTH-1:0] ins,
    output logic              en_ram_out,
    output logic [AWIDTH-1:0] pc,
    output logic              busy,
    output logic              overrun,
    output logic              fetch_err
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t            state, next_state;
    logic [7:0]        wait_cnt;
    logic              pending;
    logic [AWIDTH-1:0] pc_next;
    logic              timed_out;

    assign timed_out = (wait_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en_ram_in || pending) next_state = READ;
            READ:    if (mem_ready || timed_out) next_state = DONE;
            DONE:    next_state = pending ? READ : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = (state == READ);
        en_ram_out = (state == DONE);
        busy       = (state != IDLE) || pending;
    end

    // Relative mode sign-extends the 8-bit offset before the modulo add.
    always_comb begin
        pc_next = pc;
        case (pc_ctrl)
            2'b01:   pc_next = pc + AWIDTH'(1);
            2'b10:   pc_next = AWIDTH'(offset_addr);
            2'b11:   pc_next = pc + AWIDTH'($signed(offset_addr));
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (en_pc_pulse) pc <= pc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            ins       <= '0;
            wait_cnt  <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_ram_in || pending) begin
                        mem_addr <= pc;
                        wait_cnt <= '0;
                        // A queued request and a fresh one together: serve one, keep one.
                        pending  <= pending && en_ram_in;
                    end
                end
                READ: begin
                    if (en_ram_in) begin
                        if (pending) overrun <= 1'b1;
                        else         pending <= 1'b1;
                    end
                    if (mem_ready) begin
                        ins <= mem_rdata;
                    end else if (timed_out) begin
                        ins       <= '0;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The pending slot is consumed this edge, so a new request only
                    // fits when the slot was empty.
                    if (pending && en_ram_in) overrun <= 1'b1;
                    pending <= !pending && en_ram_in;
                    if (pending) begin
                        mem_addr <= pc;
                        wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by randomized
// fetches with random PC updates, checked against an arithmetic reference model.
module tb_instr_fetch;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_ram_in;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ins;
    logic        en_ram_out;
    logic [7:0]  pc;
    logic        busy;
    logic        overrun;
    logic        fetch_err;

    logic [15:0] mem [256];
    logic [7:0]  model_pc;
    int          tests = 0;
    int          fails = 0;

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    instr_fetch #(.DWIDTH(16), .AWIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en_ram_in(en_ram_in), .en_pc_pulse(en_pc_pulse),
        .pc_ctrl(pc_ctrl), .offset_addr(offset_addr), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ins(ins), .en_ram_out(en_ram_out), .pc(pc), .busy(busy),
        .overrun(overrun), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_pc(input logic [7:0] cur, input logic [1:0] mode,
                                          input logic [7:0] off);
        int s;
        case (mode)
            2'd1:    return 8'((int'(cur) + 1) % 256);
            2'd2:    return off;
            2'd3: begin
                s = (off >= 8'd128) ? int'(off) - 256 : int'(off);
                return 8'((int'(cur) + s + 256) % 256);
            end
            default: return cur;
        endcase
    endfunction

    task automatic set_pc(input logic [7:0] v);
        en_pc_pulse = 1'b1; pc_ctrl = 2'b10; offset_addr = v;
        tick();
        en_pc_pulse = 1'b0;
        model_pc = v;
    endtask

    task automatic pc_op(input logic [1:0] mode, input logic [7:0] off, input logic [7:0] exp,
                         input string tag);
        en_pc_pulse = 1'b1; pc_ctrl = mode; offset_addr = off;
        tick();
        en_pc_pulse = 1'b0;
        chk(tag, pc, exp);
    endtask

    task automatic rand_pc();
        en_pc_pulse = 1'($urandom_range(0, 1));
        pc_ctrl     = 2'($urandom_range(0, 3));
        offset_addr = 8'($urandom_range(0, 255));
    endtask

    task automatic upd_model();
        if (en_pc_pulse) model_pc = ref_pc(model_pc, pc_ctrl, offset_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0; en_ram_in = 1'b0; en_pc_pulse = 1'b0; pc_ctrl = 2'b00;
        offset_addr = 8'h00; mem_ready = 1'b0; model_pc = 8'h00;
        tick(); tick();
        chk("rst_pc", pc, 8'h00);
        chk("rst_ins", ins, 16'h0000);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_outs", {mem_rd, en_ram_out, busy, overrun, fetch_err}, 5'b00000);
        rst_n = 1'b1;
        tick();

        // Zero-wait fetch from address 0
        mem[0] = 16'h1234;
        en_ram_in = 1'b1; mem_ready = 1'b1;
        tick();
        en_ram_in = 1'b0;
        chk("zw_rd", mem_rd, 1'b1);
        chk("zw_addr", mem_addr, 8'h00);
        chk("zw_strobe_early", en_ram_out, 1'b0);
        chk("zw_busy", busy, 1'b1);
        tick();
        chk("zw_strobe", en_ram_out, 1'b1);
        chk("zw_ins", ins, 16'h1234);
        chk("zw_rd_off", mem_rd, 1'b0);
        mem_ready = 1'b0;
        tick();
        chk("zw_strobe_one", en_ram_out, 1'b0);
        chk("zw_ins_hold", ins, 16'h1234);
        chk("zw_idle", busy, 1'b0);

        // Three wait cycles, with a PC update during the read
        set_pc(8'h20);
        chk("set_pc", pc, 8'h20);
        mem[8'h20] = 16'hBEEF;
        en_ram_in = 1'b1;
        tick();
        en_ram_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("wait_rd", mem_rd, 1'b1);
            chk("wait_addr", mem_addr, 8'h20);
            chk("wait_strobe", en_ram_out, 1'b0);
            en_pc_pulse = (i == 2); pc_ctrl = 2'b01;
            mem_ready = (i == 4);
            tick();
            en_pc_pulse = 1'b0;
        end
        chk("wait_strobe_t5", en_ram_out, 1'b1);
        chk("wait_ins", ins, 16'hBEEF);
        chk("wait_pc", pc, 8'h21);
        mem_ready = 1'b0;
        tick();

        // Timeout abort
        en_ram_in = 1'b1;
        tick();
        en_ram_in = 1'b0;
        for (int i = 1; i <= TO + 1; i++) begin
            chk("to_rd", mem_rd, 1'b1);
            chk("to_strobe", en_ram_out, 1'b0);
            chk("to_err_early", fetch_err, 1'b0);
            tick();
        end
        chk("to_strobe_t17", en_ram_out, 1'b1);
        chk("to_ins", ins, 16'h0000);
        chk("to_err", fetch_err, 1'b1);
        tick();
        chk("to_err_sticky", fetch_err, 1'b1);
        chk("to_idle", {en_ram_out, busy}, 2'b00);

        // PC update modes
        set_pc(8'h10);
        pc_op(2'b01, 8'h00, 8'h11, "pc_inc");
        pc_op(2'b10, 8'h40, 8'h40, "pc_abs");
        pc_op(2'b11, 8'hFE, 8'h3E, "pc_rel_neg");
        pc_op(2'b11, 8'h05, 8'h43, "pc_rel_pos");
        pc_op(2'b00, 8'h77, 8'h43, "pc_hold");
        set_pc(8'hFF);
        pc_op(2'b01, 8'h00, 8'h00, "pc_wrap");

        // Fetch and PC increment in the same cycle
        set_pc(8'h05);
        en_ram_in = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01; mem_ready = 1'b1;
        tick();
        en_ram_in = 1'b0; en_pc_pulse = 1'b0;
        chk("simul_addr", mem_addr, 8'h05);
        chk("simul_pc", pc, 8'h06);
        tick();
        chk("simul_ins", ins, mem[5]);
        tick();

        // Three back-to-back requests: two served, one dropped
        en_ram_in = 1'b1;
        tick();
        chk("b2b_t1_rd", mem_rd, 1'b1);
        tick();
        chk("b2b_t2_strobe", en_ram_out, 1'b1);
        chk("b2b_t2_ins", ins, mem[6]);
        chk("b2b_t2_ovr", overrun, 1'b0);
        tick();
        en_ram_in = 1'b0;
        chk("b2b_t3_rd", mem_rd, 1'b1);
        chk("b2b_t3_strobe", en_ram_out, 1'b0);
        chk("b2b_ovr", overrun, 1'b1);
        tick();
        chk("b2b_t4_strobe", en_ram_out, 1'b1);
        tick();
        chk("b2b_t5_idle", {mem_rd, en_ram_out, busy}, 3'b000);
        tick();
        chk("b2b_no_third", {mem_rd, en_ram_out, busy}, 3'b000);
        chk("b2b_ovr_sticky", overrun, 1'b1);

        // Reset in the middle of a read
        mem_ready = 1'b0;
        en_ram_in = 1'b1;
        tick();
        en_ram_in = 1'b0;
        chk("mrst_rd_before", mem_rd, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_outs", {mem_rd, en_ram_out, busy, overrun, fetch_err}, 5'b00000);
        chk("mrst_pc", pc, 8'h00);
        tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_quiet", {mem_rd, en_ram_out, busy}, 3'b000);
        end
        mem_ready = 1'b0;

        // Randomized fetches with random PC activity
        set_pc(8'($urandom_range(0, 255)));
        for (int t = 0; t < 40; t++) begin
            int lat;
            logic [7:0] p;
            lat = $urandom_range(0, 4);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                rand_pc();
                tick();
                upd_model();
                chk("rnd_idle_pc", pc, model_pc);
                chk("rnd_idle_busy", busy, 1'b0);
            end
            p = model_pc;
            en_ram_in = 1'b1;
            rand_pc();
            tick();
            upd_model();
            en_ram_in = 1'b0;
            for (int i = 0; i <= lat; i++) begin
                chk("rnd_rd", mem_rd, 1'b1);
                chk("rnd_addr", mem_addr, p);
                chk("rnd_strobe_early", en_ram_out, 1'b0);
                chk("rnd_pc", pc, model_pc);
                rand_pc();
                mem_ready = (i == lat);
                tick();
                upd_model();
            end
            chk("rnd_strobe", en_ram_out, 1'b1);
            chk("rnd_ins", ins, mem[p]);
            chk("rnd_pc_done", pc, model_pc);
            mem_ready = 1'b0; en_pc_pulse = 1'b0;
            tick();
            chk("rnd_strobe_one", {en_ram_out, busy}, 2'b00);
            chk("rnd_flags", {overrun, fetch_err}, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
